lns_sum_backend: RTL and testbench
==================================

LNS_SUM_BACKEND -- requirements
Module: lns_sum_backend

Interface
REQ-001 SHALL have parameter FRAC, default 4: number of fractional bits in the fixed-point log-domain word.
REQ-002 SHALL take operand width from the `WBITS macro (size.v); all data ports are signed [`WBITS:1].
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: the input operand set is valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the operand set this cycle.
REQ-007 SHALL have port x, input, `WBITS: first log-domain operand.
REQ-008 SHALL have port y, input, `WBITS: second log-domain operand.
REQ-009 SHALL have port d, input, `WBITS: the comparator magnitude |x-y|.
REQ-010 SHALL have port x_greater, input, 1: the comparator flag; 1 selects x as the larger operand.
REQ-011 SHALL have port out_valid, output, 1: z and ovf are valid.
REQ-012 SHALL have port out_ready, input, 1: the downstream block accepts z.
REQ-013 SHALL have port z, output, `WBITS: the log-domain sum max(x,y)+sb(d).
REQ-014 SHALL have port ovf, output, 1: the sum exceeded `MAX.

Function
REQ-015 SHALL accept an operand set on any rising edge where in_valid && in_ready.
REQ-016 Stage 1 SHALL register m = x_greater ? x : y, k = d >>> FRAC (integer part) and f = d[FRAC:1] (fraction), plus a valid bit v1.
REQ-017 Stage 2 SHALL compute c = (ONE - (f >> 1)) >> k, with ONE = 1 << FRAC; c = 0 when k >= `WBITS or when d is negative.
REQ-018 Stage 2 SHALL register z = m + c, evaluated one bit wider, and set ovf when the wide sum exceeds `MAX.
REQ-019 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held at 1.
REQ-020 Throughput SHALL be one result per cycle with no bubbles while out_ready = 1.
REQ-021 Stage 2 SHALL hold its data when out_valid && !out_ready; z, ovf and out_valid SHALL remain stable until the result is accepted.
REQ-022 Stage 1 SHALL advance only when stage 2 is empty or is draining in the same cycle.
REQ-023 in_ready SHALL be !v1 || stage-1-advances; it SHALL be combinational from out_ready with no path from in_valid.
REQ-024 When the output transfers and a new input is accepted in the same cycle, both SHALL occur with no loss or duplication.
REQ-025 in_ready SHALL fall only when both stages hold unaccepted data.
REQ-026 x_greater SHALL be honoured as given; the block SHALL NOT recompare x and y, and for d = 0 either selection is valid.

Reset
REQ-027 Assertion of rst_n = 0 SHALL immediately clear v1, out_valid and ovf, and drive z to 0, regardless of clk.
REQ-028 While reset is held, in_ready SHALL be 1.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight results; no result SHALL appear after release unless new inputs are accepted.
REQ-030 Data registers other than z MAY be left unreset.

Configuration
REQ-031 With LNS_SAT_EN defined, an overflowing sum SHALL set z = `MAX and ovf = 1.
REQ-032 With LNS_SAT_EN undefined, z SHALL be the two's-complement wrap of m + c (low `WBITS bits) and ovf SHALL still report the overflow.

Verification (WBITS=8, FRAC=4, MAX=127)
REQ-033 x=16, y=16, d=0, x_greater=0, out_ready=1 -> after 2 cycles, z=32, ovf=0.
REQ-034 x=48, y=16, d=32, x_greater=1 -> c=4, z=52; with the operands swapped and x_greater=0 -> z=52.
REQ-035 x=-40, y=20, d=60, x_greater=0 -> k=3, f=12, c=(16-6)>>3=1, z=21.
REQ-036 x=127, d=0, x_greater=1 -> with LNS_SAT_EN, z=127 and ovf=1; without it, z=-113 and ovf=1.
REQ-037 Stream 4 sets with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, z is held stable, and all 4 results emerge in order once out_ready=1.
REQ-038 Assert rst_n=0 with 2 results in flight -> out_valid=0 immediately; after release with in_valid=0, no out_valid pulse appears.

Source files
------------

// File: rtl/size.v
// rtl/size.v - operand width and overflow bound for the LNS datapath
`ifndef SIZE_V
`define SIZE_V
`define WBITS 8
`define MAX 127
`endif

// File: rtl/lns_sum_backend.sv
// rtl/lns_sum_backend.sv - two-stage LNS sum backend z = max(x,y) + sb(|x-y|); LNS_SAT_EN enables saturation
`include "size.v"

module lns_sum_backend #(
  parameter int FRAC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [`WBITS:1] x,
  input  logic signed [`WBITS:1] y,
  input  logic signed [`WBITS:1] d,
  input  logic                   x_greater,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [`WBITS:1] z,
  output logic                   ovf
);

  localparam int W = `WBITS;
  localparam logic signed [W+1:1] MAX_W = (W+1)'(`MAX);
  localparam logic [FRAC+1:1]     ONE   = (FRAC+1)'(1) << FRAC;

  // Stage 1 state: valid bit is reset, operand fields are plain data.
  logic                 v1_q, v1_d;
  logic signed [W:1]    m_q, m_d;
  logic signed [W:1]    k_q, k_d;
  logic [FRAC:1]        f_q, f_d;

  // Stage 2 state: the output register.
  logic                 out_valid_q, out_valid_d;
  logic signed [W:1]    z_q, z_d;
  logic                 ovf_q, ovf_d;

  logic                 adv2;
  logic                 accept;
  logic [FRAC+1:1]      base;
  logic [W+1:1]         c;
  logic signed [W+1:1]  sum_wide;
  logic                 ovf_w;
  logic signed [W:1]    z_next;

  // Handshake: stage 2 can take new data when empty or draining; in_ready never looks at in_valid.
  always_comb begin
    adv2     = !out_valid_q || out_ready;
    in_ready = !v1_q || adv2;
    accept   = in_valid && in_ready;
  end

  // Stage 1 next state: capture the larger operand and split d into integer and fraction.
  always_comb begin
    v1_d = v1_q;
    m_d  = m_q;
    k_d  = k_q;
    f_d  = f_q;
    if (accept) begin
      v1_d = 1'b1;
      m_d  = x_greater ? x : y;
      k_d  = d >>> FRAC;
      f_d  = d[FRAC:1];
    end else if (adv2) begin
      v1_d = 1'b0;
    end
  end

  // Stage 2 datapath: sb(d) approximation, one-bit-wider sum and overflow detection.
  always_comb begin
    base = ONE - (FRAC+1)'(f_q >> 1);
    // A negative d gives a negative k after the arithmetic shift, so both cases zero the correction.
    if (k_q < 0 || k_q >= W) begin
      c = '0;
    end else begin
      c = (W+1)'(base) >> $unsigned(k_q);
    end
    sum_wide = $signed({m_q[W], m_q}) + $signed(c);
    ovf_w    = sum_wide > MAX_W;
`ifdef LNS_SAT_EN
    z_next   = ovf_w ? MAX_W[W:1] : sum_wide[W:1];
`else
    z_next   = sum_wide[W:1];
`endif
  end

  // Stage 2 next state: load only when advancing, otherwise hold the pending result.
  always_comb begin
    out_valid_d = out_valid_q;
    z_d         = z_q;
    ovf_d       = ovf_q;
    if (adv2) begin
      out_valid_d = v1_q;
      if (v1_q) begin
        z_d   = z_next;
        ovf_d = ovf_w;
      end
    end
  end

  // Control and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      ovf_q       <= ovf_d;
    end
  end

  // Stage 1 operand registers; meaningless while v1 is low so they need no reset.
  always_ff @(posedge clk) begin
    m_q <= m_d;
    k_q <= k_d;
    f_q <= f_d;
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_lns_sum_backend.sv
// tb/tb_lns_sum_backend.sv - directed self-checking bench for lns_sum_backend
`include "size.v"

module tb_lns_sum_backend;

  localparam int W = `WBITS;
`ifdef LNS_SAT_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic x_greater = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic ovf;
  logic signed [W:1] x = '0;
  logic signed [W:1] y = '0;
  logic signed [W:1] d = '0;
  logic signed [W:1] z;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lns_sum_backend #(.FRAC(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x(x),
    .y(y),
    .d(d),
    .x_greater(x_greater),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z(z),
    .ovf(ovf)
  );

  task automatic send(input int xi, input int yi, input int di, input logic xg);
    @(negedge clk);
    x = W'(xi);
    y = W'(yi);
    d = W'(di);
    x_greater = xg;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    total++; if (z !== '0) begin bad++; $display("FAIL reset_z got %0d want 0", z); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(16, 16, 0, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early out_valid got %0b want 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid got %0b want 1", out_valid); end
    total++; if (z !== W'(32)) begin bad++; $display("FAIL latency_z got %0d want 32", z); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL latency_ovf got %0b want 0", ovf); end
  endtask

  task automatic test_vectors();
    int vx [8] = '{48, 16, -40, 10, 127, -128, 100, 120};
    int vy [8] = '{16, 48, 20, 5, 127, -128, 0, 110};
    int vd [8] = '{32, 32, 60, -16, 0, 0, 100, 10};
    logic vg [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int ez [8] = '{52, 52, 21, 10, (SAT != 0) ? 127 : -113, -112, 100, (SAT != 0) ? 127 : -125};
    logic eo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic signed [W:1] ez_w;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vx[i], vy[i], vd[i], vg[i]);
      @(negedge clk);
      ez_w = W'(ez[i]);
      total++;
      if (out_valid !== 1'b1 || z !== ez_w || ovf !== eo[i]) begin
        bad++;
        $display("FAIL vec%0d got valid=%0b z=%0d ovf=%0b want valid=1 z=%0d ovf=%0b", i, out_valid, z, ovf, ez_w, eo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [W:1] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        exp = W'(10 * (i - 2) + 16);
        total++;
        if (out_valid !== 1'b1 || z !== exp) begin
          bad++;
          $display("FAIL b2b_out%0d got valid=%0b z=%0d want valid=1 z=%0d", i - 2, out_valid, z, exp);
        end
      end
      if (i < 4) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready%0d got %0b want 1", i, in_ready); end
        x = W'(10 * i);
        y = x;
        d = '0;
        x_greater = 1'b1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n_in = 0;
    int n_out = 0;
    logic signed [W:1] exp;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      #1;
      if (cyc == 2) begin
        total++;
        if (in_ready !== 1'b0 || n_in != 2) begin
          bad++;
          $display("FAIL bp_in_ready_fall got in_ready=%0b accepts=%0d want in_ready=0 accepts=2", in_ready, n_in);
        end
        total++;
        if (out_valid !== 1'b1 || z !== W'(17)) begin
          bad++;
          $display("FAIL bp_hold got valid=%0b z=%0d want valid=1 z=17", out_valid, z);
        end
      end
      if (out_valid && out_ready) begin
        exp = W'(17 + n_out);
        total++;
        if (z !== exp) begin bad++; $display("FAIL bp_order%0d got z=%0d want %0d", n_out, z, exp); end
        n_out++;
      end
      if (n_in < 4) begin
        x = W'(n_in + 1);
        y = x;
        d = '0;
        x_greater = 1'b1;
        in_valid = 1'b1;
        if (in_ready) n_in++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (n_out != 4 || n_in != 4) begin
      bad++;
      $display("FAIL bp_count got in=%0d out=%0d want in=4 out=4", n_in, n_out);
    end
  endtask

  task automatic test_reset_inflight();
    logic seen = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    x = W'(127); y = W'(127); d = '0; x_greater = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    x = W'(1); y = W'(1);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL rst_setup got valid=%0b ovf=%0b want valid=1 ovf=1", out_valid, ovf);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got %0b want 0", out_valid); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_async_ovf got %0b want 0", ovf); end
    total++; if (z !== '0) begin bad++; $display("FAIL rst_async_z got %0d want 0", z); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rst_no_ghost got pulse=%0b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
